// File: rtl/mem_bus_arbiter.sv
// Two-port (I-cache / D-cache) arbiter for the line-wide memory bus.
// Flat bus layout: req = {addr[57:0], data[511:0], load, store}, resp = {data[511:0], ready}.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [571:0] i_req,
  output logic [512:0] i_resp,
  input  logic [571:0] d_req,
  output logic [512:0] d_resp,
  output logic [571:0] mem_req,
  input  logic [512:0] mem_resp,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         proto_err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e         state_q, state_d;
  logic [57:0]    addr_q, addr_d;
  logic [511:0]   data_q, data_d;
  logic           load_q, load_d;
  logic           store_q, store_d;
  logic [1:0]     own_q, own_d;
  logic [511:0]   line_q, line_d;
  logic           line_own_d_q, line_own_d_d;
  logic [CW-1:0]  starve_q, starve_d;
  logic           perr_q, perr_d;

  logic           i_vld, d_vld, grant_i, grant_d;
  logic [571:0]   sel;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    load_d       = load_q;
    store_d      = store_q;
    own_d        = own_q;
    line_d       = line_q;
    line_own_d_d = line_own_d_q;
    starve_d     = starve_q;
    perr_d       = perr_q;

    i_vld   = i_req[1] | i_req[0];
    d_vld   = d_req[1] | d_req[0];
    // D normally wins; I wins once it has watched STARVE_LIMIT D grants in a row
    grant_i = i_vld && (!d_vld || starve_q == CW'(STARVE_LIMIT));
    grant_d = d_vld && !grant_i;
    sel     = grant_i ? i_req : d_req;

    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          addr_d  = sel[571:514];
          data_d  = sel[513:2];
          load_d  = sel[1] & ~sel[0];
          store_d = sel[0];
          if (sel[1] && sel[0]) perr_d = 1'b1;
          own_d   = grant_i ? 2'b01 : 2'b10;
          state_d = WAIT;
          if (grant_i || !i_vld)                  starve_d = '0;
          else if (starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
        end
      end
      WAIT: begin
        if (mem_resp[0]) begin
          line_d       = mem_resp[512:1];
          line_own_d_d = own_q[1];
          load_d       = 1'b0;
          store_d      = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        own_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      own_q        <= 2'b00;
      line_q       <= '0;
      line_own_d_q <= 1'b0;
      starve_q     <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      load_q       <= load_d;
      store_q      <= store_d;
      own_q        <= own_d;
      line_q       <= line_d;
      line_own_d_q <= line_own_d_d;
      starve_q     <= starve_d;
      perr_q       <= perr_d;
    end
  end

  // Captured line is visible only to the requester that owns it
  assign i_resp    = {line_own_d_q ? 512'd0 : line_q, (state_q == DONE) && own_q[0]};
  assign d_resp    = {line_own_d_q ? line_q : 512'd0, (state_q == DONE) && own_q[1]};
  assign mem_req   = {addr_q, data_q, load_q, store_q};
  assign owner     = own_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration order, starvation, latency, proto_err and reset.
module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [571:0] i_req, d_req, mem_req;
  logic [512:0] i_resp, d_resp, mem_resp;
  logic [1:0]   owner;
  logic         busy, proto_err;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_resp(i_resp),
    .d_req(d_req), .d_resp(d_resp),
    .mem_req(mem_req), .mem_resp(mem_resp),
    .owner(owner), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [571:0] mk(input logic [57:0] a, input logic [511:0] d,
                                      input logic l, input logic s);
    return {a, d, l, s};
  endfunction

  // Memory model: waits for a valid mem_req, answers on the lat-th visible cycle.
  // Returns at the negedge of the DONE cycle with mem_resp cleared.
  task automatic mem_serve(input int lat, input logic [511:0] line,
                           output int nvis, output logic [571:0] snap);
    nvis = 0;
    snap = '0;
    for (int t = 0; t < 20 && !(mem_req[1] | mem_req[0]); t++) @(negedge clk);
    if (!(mem_req[1] | mem_req[0])) begin
      checks++; errors++;
      $display("FAIL mem_serve_timeout: no mem_req within 20 cycles");
      return;
    end
    snap = mem_req;
    for (int c = 1; c <= lat; c++) begin
      if (mem_req[1] | mem_req[0]) nvis++;
      if (c == lat) mem_resp = {line, 1'b1};
      @(negedge clk);
    end
    mem_resp = '0;
  endtask

  task automatic wait_grant(output logic [1:0] o);
    for (int t = 0; t < 20 && owner == 2'b00; t++) @(negedge clk);
    o = owner;
    if (owner == 2'b00) begin
      checks++; errors++;
      $display("FAIL wait_grant_timeout: owner stayed 0");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = '0; d_req = '0; mem_resp = '0;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== '0) begin errors++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
    checks++; if (i_resp !== '0 || d_resp !== '0) begin errors++; $display("FAIL reset_resp: got i.rdy=%b d.rdy=%b want 0", i_resp[0], d_resp[0]); end
    checks++; if ({owner, busy, proto_err} !== 4'b0) begin errors++; $display("FAIL reset_status: got %b want 0000", {owner, busy, proto_err}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    logic [511:0] l1 = {16{32'h1111_0010}};
    int nv; logic [571:0] sn;
    i_req = mk(58'h10, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (owner !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL t1_owner: got %b/%b want 01/1", owner, busy); end
    checks++; if (i_resp[0] !== 1'b0) begin errors++; $display("FAIL t1_early_ready: got %b want 0", i_resp[0]); end
    mem_serve(3, l1, nv, sn);
    checks++; if (sn !== mk(58'h10, '0, 1'b1, 1'b0)) begin errors++; $display("FAIL t1_mem_req: got addr %h ls %b want addr 10 ls 10", sn[571:514], sn[1:0]); end
    checks++; if (nv !== 3) begin errors++; $display("FAIL t1_req_cycles: got %0d want 3", nv); end
    checks++; if (i_resp !== {l1, 1'b1}) begin errors++; $display("FAIL t1_i_resp: got rdy %b data %h want rdy 1", i_resp[0], i_resp[64:1]); end
    checks++; if (d_resp !== '0) begin errors++; $display("FAIL t1_d_resp: got %h want 0", d_resp[64:0]); end
    checks++; if (mem_req[1:0] !== 2'b00) begin errors++; $display("FAIL t1_mem_clear: got %b want 00", mem_req[1:0]); end
    i_req = '0;
    @(negedge clk);
    checks++; if (i_resp !== {l1, 1'b0} || busy !== 1'b0) begin errors++; $display("FAIL t1_after: got rdy %b busy %b want 0 0 with line held", i_resp[0], busy); end
  endtask

  task automatic test_both_valid();
    logic [511:0] ld = {16{32'hD00D_0002}};
    logic [511:0] li = {16{32'h1CE0_0001}};
    int nv; logic [571:0] sn;
    i_req = mk(58'h21, '0, 1'b1, 1'b0);
    d_req = mk(58'h22, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (owner !== 2'b10) begin errors++; $display("FAIL t2_first_owner: got %b want 10", owner); end
    mem_serve(1, ld, nv, sn);
    checks++; if (d_resp !== {ld, 1'b1} || i_resp !== '0) begin errors++; $display("FAIL t2_d_done: got d.rdy %b i %h want 1, 0", d_resp[0], i_resp[64:0]); end
    d_req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL t2_second_owner: got %b want 01", owner); end
    mem_serve(2, li, nv, sn);
    checks++; if (i_resp !== {li, 1'b1} || d_resp !== '0) begin errors++; $display("FAIL t2_i_done: got i.rdy %b d %h want 1, 0", i_resp[0], d_resp[64:0]); end
    i_req = '0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [1:0] exp [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [1:0] o;
    int nv; logic [571:0] sn;
    i_req = mk(58'h31, '0, 1'b1, 1'b0);
    d_req = mk(58'h32, '0, 1'b1, 1'b0);
    for (int g = 0; g < 10; g++) begin
      wait_grant(o);
      checks++; if (o !== exp[g]) begin errors++; $display("FAIL t3_grant%0d: got %b want %b", g, o, exp[g]); end
      mem_serve(1, {16{32'h5000_0000 + g}}, nv, sn);
      @(negedge clk);
    end
    i_req = '0; d_req = '0;
    @(negedge clk);
  endtask

  task automatic test_d_store();
    logic [511:0] aa = {64{8'hAA}};
    logic [511:0] lm = {16{32'h600D_003F}};
    int nv; logic [571:0] sn;
    d_req = mk(58'h3F, aa, 1'b0, 1'b1);
    @(negedge clk);
    mem_serve(2, lm, nv, sn);
    checks++; if (sn !== mk(58'h3F, aa, 1'b0, 1'b1)) begin errors++; $display("FAIL t4_mem_req: got addr %h ls %b data %h want 3f 01 aa..", sn[571:514], sn[1:0], sn[65:2]); end
    checks++; if (d_resp !== {lm, 1'b1} || i_resp !== '0) begin errors++; $display("FAIL t4_done: got d.rdy %b i.rdy %b want 1 0", d_resp[0], i_resp[0]); end
    d_req = '0;
    @(negedge clk);
    checks++; if (d_resp[0] !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL t4_pulse: got rdy %b perr %b want 0 0", d_resp[0], proto_err); end
  endtask

  task automatic test_proto_err();
    int nv; logic [571:0] sn;
    i_req = mk(58'h55, 512'h5, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (mem_req[1:0] !== 2'b01 || proto_err !== 1'b1) begin errors++; $display("FAIL t5_forward: got ls %b perr %b want 01 1", mem_req[1:0], proto_err); end
    mem_serve(1, '1, nv, sn);
    i_req = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t5_sticky: got %b want 1", proto_err); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t5_clear: got %b want 0", proto_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_req = mk(58'h77, '0, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t6_in_wait: got busy %b want 1", busy); end
    rst = 1'b0; d_req = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || owner !== 2'b00 || mem_req !== '0) begin errors++; $display("FAIL t6_reset: got busy %b owner %b mem_ls %b want 0 00 00", busy, owner, mem_req[1:0]); end
    rst = 1'b1;
    mem_resp = {{16{32'hBAD0_BAD0}}, 1'b1};
    @(negedge clk);
    mem_resp = '0;
    checks++; if (busy !== 1'b0 || d_resp !== '0 || i_resp !== '0) begin errors++; $display("FAIL t6_stray: got busy %b d.rdy %b i.rdy %b want 0 0 0", busy, d_resp[0], i_resp[0]); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL t6_stay_idle: got busy %b owner %b want 0 00", busy, owner); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_both_valid();
    test_starvation();
    test_d_store();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
